lisnoc_dma_request_dispatch: RTL and testbench
==============================================

Name: lisnoc_dma_request_dispatch

Overview:
Control-side consumer of the DMA request table. It scans the table's per-entry valid vector with a round-robin arbiter, reads the selected request through the table's control read port, and hands it to the transfer engine over a valid/ready handshake. It then waits for engine completion (or a timeout) and pulses the table's done strobe for that entry. Only one transfer is in flight at a time.

Parameters:
table_entries, 4, number of request table entries; pointer width is fixed at 2 bits (localparam ptrwidth = 2).
timeout_width, 16, width of the completion-timeout counter.
timeout_cycles, 0, cycles in WAIT before a forced completion; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
valid  in  table_entries  per-entry "pending, not done" flags from the request table
ctrl_read_pos  out  ptrwidth  table read index (registered)
ctrl_read_req  in  `DMA_REQUEST_WIDTH  request word at ctrl_read_pos (combinational table read)
ctrl_done_pos  out  ptrwidth  index to mark done
ctrl_done_en  out  1  one-cycle done strobe
eng_req  out  `DMA_REQUEST_WIDTH  registered request presented to the engine
eng_req_valid  out  1  request offer
eng_req_ready  in  1  engine accepts request
eng_done  in  1  engine completion pulse for the accepted request
active  out  1  high in every state except IDLE
timeout_err  out  1  sticky flag, set on forced completion
err_clear  in  1  clears timeout_err

Behaviour:
- Reset (async, active-high): state=IDLE; last_grant=table_entries-1, so entry 0 has first priority. All outputs are 0: ctrl_read_pos, ctrl_done_pos, ctrl_done_en, eng_req, eng_req_valid, active, timeout_err. The timeout counter is 0.
- Reset mid-operation aborts the transfer immediately. No done strobe is issued for the aborted entry.
- FSM states: IDLE, READ, ISSUE, WAIT, DONE.
- IDLE:
  - If |valid, select the first set bit searching from last_grant+1 upward, wrapping modulo table_entries.
  - Register the selection into ctrl_read_pos and sel, then go to READ.
  - If no valid bit is set, stay in IDLE.
- READ:
  - If valid[sel]==0 (entry was cancelled), return to IDLE; last_grant is unchanged.
  - Otherwise capture ctrl_read_req into eng_req and go to ISSUE.
- ISSUE:
  - eng_req_valid=1; eng_req is held stable.
  - If eng_req_ready==1: the handshake completes, last_grant<=sel, counter<=0, go to WAIT. The handshake takes precedence over a same-cycle valid[sel] drop.
  - Else if valid[sel]==0: drop eng_req_valid and return to IDLE with no done strobe.
- WAIT:
  - eng_req_valid=0 and the counter increments every cycle. eng_done is sampled only in this state; eng_done in any other state is ignored.
  - On eng_done==1: go to DONE.
  - Else if timeout_cycles!=0 and counter==timeout_cycles-1: set timeout_err and go to DONE.
  - A cancelled valid[sel] in WAIT is ignored; an accepted transfer always completes.
  - The counter saturates at its maximum value and never wraps.
- DONE:
  - ctrl_done_en=1 and ctrl_done_pos=sel for exactly one cycle, then go to IDLE.
  - The table clears valid[sel] at that edge, so IDLE never re-selects the same entry.
- Latency:
  - valid sampled in IDLE at edge t → eng_req_valid high from cycle t+2.
  - eng_done sampled at edge n → ctrl_done_en high in cycle n+1 → IDLE at n+2.
  - Minimum dispatch period is 5 cycles with ready and done immediate.
- timeout_err:
  - Cleared by err_clear at the next edge.
  - If a set and a clear occur in the same cycle, set wins.
- Round-robin fairness: an entry that has just been granted has the lowest priority at the next arbitration. With all entries continuously valid, grants follow the order 0,1,2,3,0,...
- active = (state != IDLE).

Test Plan:
- Single request: valid=4'b0100, ready tied high, eng_done pulsed 3 cycles after the handshake → ctrl_read_pos=2; eng_req equals the table word; exactly one ctrl_done_en pulse with pos=2; 5 dispatch cycles plus the engine delay.
- Fairness: valid=4'b1111 held, each entry dropped on its own done pulse → grant order 0,1,2,3; then re-assert 4'b0011 → next grant is 0.
- Backpressure and cancel: eng_req_ready=0 for 10 cycles with eng_req held stable, then valid[sel] dropped → eng_req_valid falls, FSM returns to IDLE, no ctrl_done_en. Repeat with ready and the valid drop in the same cycle → handshake taken, FSM enters WAIT.
- Timeout: timeout_cycles=8, eng_done never asserted → ctrl_done_en pulses 8 cycles after entering WAIT and timeout_err=1. err_clear clears it; err_clear coinciding with a new timeout leaves timeout_err=1.
- Spurious completion: eng_done pulsed in IDLE and in ISSUE → ignored, no done strobe issued.
- Async reset in WAIT: assert rst mid-cycle → all outputs 0 immediately, no done strobe; after release, valid=4'b0001 → entry 0 is granted first.

Source files
------------

// File: rtl/lisnoc_dma_request_dispatch.sv
// DMA request dispatcher: round-robin pick of a pending table entry, read it
// through the table control port, offer it to the engine, wait for completion
// (or a timeout) and strobe the table's done port. One transfer at a time.
`ifndef DMA_REQUEST_WIDTH
`define DMA_REQUEST_WIDTH 32
`endif

module lisnoc_dma_request_dispatch #(
  parameter int table_entries  = 4,
  parameter int timeout_width  = 16,
  parameter int timeout_cycles = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [table_entries-1:0]      valid,
  output logic [1:0]                    ctrl_read_pos,
  input  logic [`DMA_REQUEST_WIDTH-1:0] ctrl_read_req,
  output logic [1:0]                    ctrl_done_pos,
  output logic                          ctrl_done_en,
  output logic [`DMA_REQUEST_WIDTH-1:0] eng_req,
  output logic                          eng_req_valid,
  input  logic                          eng_req_ready,
  input  logic                          eng_done,
  output logic                          active,
  output logic                          timeout_err,
  input  logic                          err_clear
);
  localparam int ptrwidth = 2;

  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, DONE} state_t;

  state_t                   r_state;
  logic [ptrwidth-1:0]      r_sel;
  logic [ptrwidth-1:0]      r_last_grant;
  logic [timeout_width-1:0] r_cnt;

  logic [ptrwidth-1:0]      w_pick;
  logic                     w_any;
  logic                     w_sel_valid;
  logic                     w_timeout;
  logic                     w_cnt_max;

  // Round-robin pick: nearest set bit after last_grant. The loop walks from the
  // farthest distance down so the closest candidate is the one that sticks.
  always_comb begin
    int idx;
    w_any  = |valid;
    w_pick = '0;
    for (int d = table_entries; d >= 1; d--) begin
      idx = (int'(r_last_grant) + d) % table_entries;
      if (valid[idx]) w_pick = ptrwidth'(idx);
    end
  end

  assign w_sel_valid = valid[r_sel];
  assign w_cnt_max   = &r_cnt;
  assign w_timeout   = (timeout_cycles != 0) &&
                       (r_cnt == timeout_width'(timeout_cycles - 1));
  assign active      = (r_state != IDLE);

  // Dispatch FSM with registered handshake/strobe outputs and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sel         <= '0;
      r_last_grant  <= ptrwidth'(table_entries - 1);
      r_cnt         <= '0;
      ctrl_read_pos <= '0;
      ctrl_done_pos <= '0;
      ctrl_done_en  <= 1'b0;
      eng_req       <= '0;
      eng_req_valid <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      // A timeout set later in this block overrides the clear.
      if (err_clear) timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel         <= w_pick;
            ctrl_read_pos <= w_pick;
            r_state       <= READ;
          end
        end
        READ: begin
          if (!w_sel_valid) begin
            r_state <= IDLE;
          end else begin
            eng_req       <= ctrl_read_req;
            eng_req_valid <= 1'b1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Handshake wins over a same-cycle cancel.
          if (eng_req_ready) begin
            eng_req_valid <= 1'b0;
            r_last_grant  <= r_sel;
            r_cnt         <= '0;
            r_state       <= WAIT;
          end else if (!w_sel_valid) begin
            eng_req_valid <= 1'b0;
            r_state       <= IDLE;
          end
        end
        WAIT: begin
          if (!w_cnt_max) r_cnt <= r_cnt + 1'b1;
          if (eng_done) begin
            ctrl_done_en  <= 1'b1;
            ctrl_done_pos <= r_sel;
            r_state       <= DONE;
          end else if (w_timeout) begin
            timeout_err   <= 1'b1;
            ctrl_done_en  <= 1'b1;
            ctrl_done_pos <= r_sel;
            r_state       <= DONE;
          end
        end
        DONE: begin
          ctrl_done_en <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lisnoc_dma_request_dispatch.sv
// Bench for lisnoc_dma_request_dispatch: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
`ifndef DMA_REQUEST_WIDTH
`define DMA_REQUEST_WIDTH 32
`endif

module tb_lisnoc_dma_request_dispatch;
  localparam int W  = `DMA_REQUEST_WIDTH;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   valid = '0;
  logic [1:0]   ctrl_read_pos, ctrl_done_pos;
  logic [W-1:0] ctrl_read_req, eng_req;
  logic         ctrl_done_en, eng_req_valid, active, timeout_err;
  logic         eng_req_ready = 1'b0, eng_done = 1'b0, err_clear = 1'b0;

  logic [W-1:0] tbl [4];
  assign ctrl_read_req = tbl[ctrl_read_pos];

  lisnoc_dma_request_dispatch #(.table_entries(4), .timeout_width(16), .timeout_cycles(TO)) dut (
    .clk(clk), .rst(rst), .valid(valid),
    .ctrl_read_pos(ctrl_read_pos), .ctrl_read_req(ctrl_read_req),
    .ctrl_done_pos(ctrl_done_pos), .ctrl_done_en(ctrl_done_en),
    .eng_req(eng_req), .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
    .eng_done(eng_done), .active(active), .timeout_err(timeout_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int grant_q[$], done_q[$];
  bit auto_eng = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expire(input string name);
    n_tests++; n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- transaction-level model ----------------
  localparam int P_IDLE = 0, P_READ = 1, P_ISSUE = 2, P_WAIT = 3, P_DONE = 4;
  int m_ph, m_sel, m_last, m_rpos, m_dpos, m_cnt;
  logic [W-1:0] m_req;
  bit m_err;

  function automatic int rr(input logic [3:0] v, input int last);
    for (int d = 1; d <= 4; d++)
      if (v[(last + d) % 4]) return (last + d) % 4;
    return -1;
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE; m_sel = 0; m_last = 3; m_rpos = 0; m_dpos = 0; m_cnt = 0;
    m_req = '0; m_err = 0;
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so the negedge view
  // is exactly what the next edge samples.
  task automatic m_advance();
    bit set_err = 0;
    case (m_ph)
      P_IDLE: if (valid != 0) begin m_sel = rr(valid, m_last); m_rpos = m_sel; m_ph = P_READ; end
      P_READ: if (!valid[m_sel]) m_ph = P_IDLE;
              else begin m_req = tbl[m_sel]; m_ph = P_ISSUE; end
      P_ISSUE: if (eng_req_ready) begin m_last = m_sel; m_cnt = 0; m_ph = P_WAIT; end
               else if (!valid[m_sel]) m_ph = P_IDLE;
      P_WAIT: begin
        if (eng_done) begin m_ph = P_DONE; m_dpos = m_sel; end
        else if (m_cnt == TO - 1) begin set_err = 1; m_ph = P_DONE; m_dpos = m_sel; end
        if (m_cnt < 65535) m_cnt++;
      end
      default: m_ph = P_IDLE;
    endcase
    if (set_err) m_err = 1;
    else if (err_clear) m_err = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      check("m_active",        64'(active),        64'(m_ph != P_IDLE));
      check("m_eng_req_valid", 64'(eng_req_valid), 64'(m_ph == P_ISSUE));
      check("m_done_en",       64'(ctrl_done_en),  64'(m_ph == P_DONE));
      check("m_read_pos",      64'(ctrl_read_pos), 64'(m_rpos));
      check("m_done_pos",      64'(ctrl_done_pos), 64'(m_dpos));
      check("m_eng_req",       64'(eng_req),       64'(m_req));
      check("m_timeout_err",   64'(timeout_err),   64'(m_err));
      if (!rst) m_advance();
    end
  end

  // One clock: record handshakes/done strobes seen before the edge, emulate the
  // table clearing the done entry, and optionally answer with an immediate done.
  task automatic tick(input int n);
    bit d_en, hs; int d_pos, h_pos;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d_en = ctrl_done_en; d_pos = int'(ctrl_done_pos);
      hs = eng_req_valid && eng_req_ready && !rst; h_pos = int'(ctrl_read_pos);
      @(posedge clk); #1;
      cyc++;
      if (d_en) begin valid[d_pos] = 1'b0; done_q.push_back(d_pos); end
      if (hs) grant_q.push_back(h_pos);
      if (auto_eng) eng_done = hs;
    end
  endtask

  task automatic wait_idle(input string name);
    int b = 0;
    while (active && b < 60) begin tick(1); b++; end
    if (active) expire(name);
  endtask

  task automatic wait_grant(input string name);
    int n0 = grant_q.size(), b = 0;
    while (grant_q.size() == n0 && b < 40) begin tick(1); b++; end
    if (grant_q.size() == n0) expire(name);
  endtask

  task automatic wait_offer(input string name);
    int b = 0;
    while (!eng_req_valid && b < 40) begin tick(1); b++; end
    if (!eng_req_valid) expire(name);
  endtask

  initial begin
    int c0, nd, b;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, nd, b;
    for (int i = 0; i < 4; i++) tbl[i] = W'(32'hC0DE_0000 + i);
    #3;
    check("rst_active", 64'(active), 64'd0);
    check("rst_eng_req_valid", 64'(eng_req_valid), 64'd0);
    check("rst_done_en", 64'(ctrl_done_en), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    tick(2); rst = 1'b0;

    // Single request on entry 2, done sampled three edges after the handshake.
    eng_req_ready = 1'b1; valid = 4'b0100; c0 = cyc;
    wait_grant("t1_grant");
    check("t1_grant_pos", 64'(grant_q[0]), 64'd2);
    check("t1_eng_req", 64'(eng_req), 64'hC0DE_0002);
    tick(2); eng_done = 1'b1; tick(1); eng_done = 1'b0;
    wait_idle("t1_idle");
    check("t1_done_cnt", 64'(done_q.size()), 64'd1);
    check("t1_done_pos", 64'(done_q[0]), 64'd2);
    check("t1_cycles", 64'(cyc - c0), 64'd7);

    // Fairness from reset: grants 0,1,2,3 then 0 with 0011.
    rst = 1'b1; tick(2); rst = 1'b0;
    grant_q.delete(); done_q.delete();
    auto_eng = 1; valid = 4'b1111;
    b = 0; while ((valid != 0 || active) && b < 80) begin tick(1); b++; end
    if (valid != 0 || active) expire("t2_drain");
    check("t2_cnt", 64'(grant_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_order%0d", i), 64'(grant_q[i]), 64'(i));
    valid = 4'b0011;
    b = 0; while ((valid != 0 || active) && b < 40) begin tick(1); b++; end
    if (valid != 0 || active) expire("t2b_drain");
    check("t2b_first", 64'(grant_q[4]), 64'd0);
    check("t2b_second", 64'(grant_q[5]), 64'd1);
    auto_eng = 0; eng_done = 1'b0;

    // Backpressure then cancel: no strobe, back to idle.
    eng_req_ready = 1'b0; valid = 4'b0010; nd = done_q.size();
    wait_offer("t3_offer");
    tick(10);
    check("t3_held_valid", 64'(eng_req_valid), 64'd1);
    check("t3_held_req", 64'(eng_req), 64'hC0DE_0001);
    valid = 4'b0000; tick(1);
    check("t3_cancel_valid", 64'(eng_req_valid), 64'd0);
    check("t3_cancel_idle", 64'(active), 64'd0);
    tick(3);
    check("t3_no_done", 64'(done_q.size()), 64'(nd));
    // Ready and cancel in the same cycle: handshake taken.
    valid = 4'b0010; wait_offer("t3b_offer");
    eng_req_ready = 1'b1; valid = 4'b0000; tick(1); eng_req_ready = 1'b0;
    check("t3b_wait_active", 64'(active), 64'd1);
    check("t3b_wait_novalid", 64'(eng_req_valid), 64'd0);
    check("t3b_grant", 64'(grant_q[grant_q.size()-1]), 64'd1);
    eng_done = 1'b1; tick(1); eng_done = 1'b0;
    wait_idle("t3b_idle");
    check("t3b_done_cnt", 64'(done_q.size()), 64'(nd + 1));
    check("t3b_done_pos", 64'(done_q[done_q.size()-1]), 64'd1);

    // Timeout after 8 WAIT cycles, then clear, then clear colliding with set.
    eng_req_ready = 1'b1; valid = 4'b0001;
    wait_grant("t4_grant"); c0 = cyc; eng_req_ready = 1'b0;
    b = 0; while (!ctrl_done_en && b < 20) begin tick(1); b++; end
    if (!ctrl_done_en) expire("t4_done");
    check("t4_latency", 64'(cyc - c0), 64'd8);
    check("t4_err_set", 64'(timeout_err), 64'd1);
    tick(1);
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
    check("t4_err_cleared", 64'(timeout_err), 64'd0);
    eng_req_ready = 1'b1; valid = 4'b0001;
    wait_grant("t4b_grant"); eng_req_ready = 1'b0;
    tick(7);
    check("t4b_err_before", 64'(timeout_err), 64'd0);
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
    check("t4b_set_wins", 64'(timeout_err), 64'd1);
    check("t4b_done_en", 64'(ctrl_done_en), 64'd1);
    tick(1);
    err_clear = 1'b1; tick(1); err_clear = 1'b0;

    // Spurious completions in IDLE and ISSUE are ignored.
    nd = done_q.size();
    eng_done = 1'b1; tick(2); eng_done = 1'b0;
    check("t5_idle_nodone", 64'(done_q.size()), 64'(nd));
    check("t5_idle_inactive", 64'(active), 64'd0);
    valid = 4'b0100; wait_offer("t5_offer");
    eng_done = 1'b1; tick(1); eng_done = 1'b0;
    check("t5_issue_still", 64'(eng_req_valid), 64'd1);
    tick(1);
    check("t5_issue_nodone", 64'(done_q.size()), 64'(nd));
    eng_req_ready = 1'b1; tick(1); eng_req_ready = 1'b0;
    tick(1); eng_done = 1'b1; tick(1); eng_done = 1'b0;
    wait_idle("t5_idle");
    check("t5_one_done", 64'(done_q.size()), 64'(nd + 1));
    check("t5_done_pos", 64'(done_q[done_q.size()-1]), 64'd2);

    // Async reset while waiting: outputs drop at once, no strobe, entry 0 first.
    eng_req_ready = 1'b1; valid = 4'b0100; nd = done_q.size();
    wait_grant("t6_grant"); eng_req_ready = 1'b0;
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_active", 64'(active), 64'd0);
    check("t6_rst_req", 64'(eng_req), 64'd0);
    check("t6_rst_pos", 64'(ctrl_read_pos), 64'd0);
    check("t6_rst_done_en", 64'(ctrl_done_en), 64'd0);
    valid = 4'b0001;
    tick(2); rst = 1'b0;
    check("t6_no_done", 64'(done_q.size()), 64'(nd));
    eng_req_ready = 1'b1; wait_grant("t6b_grant"); eng_req_ready = 1'b0;
    check("t6_first_grant", 64'(grant_q[grant_q.size()-1]), 64'd0);
    eng_done = 1'b1; tick(1); eng_done = 1'b0;
    wait_idle("t6_idle");
    check("t6_done_pos", 64'(done_q[done_q.size()-1]), 64'd0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
